// File: rtl/seg_execute_alu_mc.sv
// seg_execute_alu_mc: EX-stage ALU with single-cycle logic/arith/shift/compare
// ops and an iterative shift-add multiplier / restoring divider that writes
// internal HI/LO registers. o_busy stalls the pipeline while the unit runs.
module seg_execute_alu_mc #(
  parameter int NB_DATA   = 32,
  parameter int NB_ALUCTL = 5,
  parameter int NB_SHAMT  = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic                 i_flush,
  input  logic [NB_ALUCTL-1:0] i_ALUctl,
  input  logic [NB_DATA-1:0]   i_data_a,
  input  logic [NB_DATA-1:0]   i_data_b,
  input  logic [NB_SHAMT-1:0]  i_shamt,
  output logic [NB_DATA-1:0]   o_ALUOut,
  output logic                 o_zero,
  output logic                 o_overflow,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam logic [NB_ALUCTL-1:0] OP_AND   = NB_ALUCTL'(5'b00000);
  localparam logic [NB_ALUCTL-1:0] OP_OR    = NB_ALUCTL'(5'b00001);
  localparam logic [NB_ALUCTL-1:0] OP_ADD   = NB_ALUCTL'(5'b00010);
  localparam logic [NB_ALUCTL-1:0] OP_SUB   = NB_ALUCTL'(5'b00110);
  localparam logic [NB_ALUCTL-1:0] OP_SLT   = NB_ALUCTL'(5'b00111);
  localparam logic [NB_ALUCTL-1:0] OP_SLTU  = NB_ALUCTL'(5'b01000);
  localparam logic [NB_ALUCTL-1:0] OP_NOR   = NB_ALUCTL'(5'b01100);
  localparam logic [NB_ALUCTL-1:0] OP_XOR   = NB_ALUCTL'(5'b01101);
  localparam logic [NB_ALUCTL-1:0] OP_SLL   = NB_ALUCTL'(5'b10000);
  localparam logic [NB_ALUCTL-1:0] OP_SRL   = NB_ALUCTL'(5'b10001);
  localparam logic [NB_ALUCTL-1:0] OP_SRA   = NB_ALUCTL'(5'b10010);
  localparam logic [NB_ALUCTL-1:0] OP_LUI   = NB_ALUCTL'(5'b10011);
  localparam logic [NB_ALUCTL-1:0] OP_MULT  = NB_ALUCTL'(5'b11000);
  localparam logic [NB_ALUCTL-1:0] OP_MULTU = NB_ALUCTL'(5'b11001);
  localparam logic [NB_ALUCTL-1:0] OP_DIV   = NB_ALUCTL'(5'b11010);
  localparam logic [NB_ALUCTL-1:0] OP_DIVU  = NB_ALUCTL'(5'b11011);
  localparam logic [NB_ALUCTL-1:0] OP_MFHI  = NB_ALUCTL'(5'b11100);
  localparam logic [NB_ALUCTL-1:0] OP_MFLO  = NB_ALUCTL'(5'b11101);

  localparam int NB_CNT = $clog2(NB_DATA + 1);
  localparam int MSB    = NB_DATA - 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} state_t;

  state_t                state_reg;
  logic [NB_CNT-1:0]     cnt_reg;
  logic [NB_DATA-1:0]    hi_reg;
  logic [NB_DATA-1:0]    lo_reg;
  logic [NB_DATA-1:0]    acc_hi_reg;   // product high half / partial remainder
  logic [NB_DATA-1:0]    acc_lo_reg;   // multiplier bits / dividend-quotient bits
  logic [NB_DATA-1:0]    op_b_reg;     // multiplicand or divisor magnitude
  logic                  is_div_reg;
  logic                  neg_q_reg;    // negate product / quotient at FIX
  logic                  neg_r_reg;    // negate remainder at FIX (dividend sign)
  logic                  div_zero_reg;
  logic                  done_reg;

  // Operand decode for the accept edge
  logic                  md_op;
  logic                  md_div;
  logic                  md_signed;
  logic                  sign_a;
  logic                  sign_b;
  logic [NB_DATA-1:0]    mag_a;
  logic [NB_DATA-1:0]    mag_b;

  // Per-iteration and final-correction values
  logic [NB_DATA:0]      mul_sum;
  logic [NB_DATA:0]      div_shift;
  logic                  div_ge;
  logic [NB_DATA-1:0]    div_sub;
  logic [NB_DATA-1:0]    acc_hi_next;
  logic [NB_DATA-1:0]    acc_lo_next;
  logic [2*NB_DATA-1:0]  prod_mag;
  logic [2*NB_DATA-1:0]  prod_fix;
  logic [NB_DATA-1:0]    fix_hi;
  logic [NB_DATA-1:0]    fix_lo;

  // Single-cycle datapath
  logic [NB_DATA-1:0]    add_res;
  logic [NB_DATA-1:0]    sub_res;
  logic [NB_DATA-1:0]    alu_out;
  logic                  alu_ovf;

  assign md_op     = (i_ALUctl == OP_MULT) || (i_ALUctl == OP_MULTU) ||
                     (i_ALUctl == OP_DIV)  || (i_ALUctl == OP_DIVU);
  assign md_div    = (i_ALUctl == OP_DIV)  || (i_ALUctl == OP_DIVU);
  assign md_signed = (i_ALUctl == OP_MULT) || (i_ALUctl == OP_DIV);
  assign sign_a    = md_signed & i_data_a[MSB];
  assign sign_b    = md_signed & i_data_b[MSB];
  assign mag_a     = sign_a ? -i_data_a : i_data_a;
  assign mag_b     = sign_b ? -i_data_b : i_data_b;

  // One shift-add or restoring-divide step on the accumulator pair
  always_comb begin
    mul_sum     = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, op_b_reg} : '0);
    div_shift   = {acc_hi_reg, acc_lo_reg[MSB]};
    div_ge      = div_shift >= {1'b0, op_b_reg};
    // True difference is below the divisor, so modulo-2^N arithmetic is exact
    div_sub     = div_shift[MSB:0] - op_b_reg;
    acc_hi_next = acc_hi_reg;
    acc_lo_next = acc_lo_reg;
    if (is_div_reg) begin
      acc_hi_next = div_ge ? div_sub : div_shift[MSB:0];
      acc_lo_next = {acc_lo_reg[MSB-1:0], div_ge};
    end else begin
      acc_hi_next = mul_sum[NB_DATA:1];
      acc_lo_next = {mul_sum[0], acc_lo_reg[MSB:1]};
    end
  end

  // Sign correction applied on the FIX edge
  always_comb begin
    prod_mag = {acc_hi_reg, acc_lo_reg};
    prod_fix = neg_q_reg ? -prod_mag : prod_mag;
    fix_hi   = prod_fix[2*NB_DATA-1:NB_DATA];
    fix_lo   = prod_fix[MSB:0];
    if (is_div_reg) begin
      // Remainder follows the dividend, so a zero divisor leaves HI = dividend
      fix_hi = neg_r_reg ? -acc_hi_reg : acc_hi_reg;
      fix_lo = div_zero_reg ? '1 : (neg_q_reg ? -acc_lo_reg : acc_lo_reg);
    end
  end

  // Multiply/divide sequencer and HI/LO update
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      acc_hi_reg   <= '0;
      acc_lo_reg   <= '0;
      op_b_reg     <= '0;
      is_div_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (i_flush) begin
        state_reg <= ST_IDLE;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (i_valid && md_op) begin
              acc_hi_reg   <= '0;
              acc_lo_reg   <= mag_a;
              op_b_reg     <= mag_b;
              is_div_reg   <= md_div;
              neg_q_reg    <= sign_a ^ sign_b;
              neg_r_reg    <= sign_a;
              div_zero_reg <= (i_data_b == '0);
              cnt_reg      <= NB_CNT'(NB_DATA);
              state_reg    <= ST_RUN;
            end
          end
          ST_RUN: begin
            acc_hi_reg <= acc_hi_next;
            acc_lo_reg <= acc_lo_next;
            cnt_reg    <= cnt_reg - 1'b1;
            if (cnt_reg == NB_CNT'(1)) begin
              state_reg <= ST_FIX;
            end
          end
          ST_FIX: begin
            hi_reg    <= fix_hi;
            lo_reg    <= fix_lo;
            done_reg  <= 1'b1;
            state_reg <= ST_IDLE;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign add_res = i_data_a + i_data_b;
  assign sub_res = i_data_a - i_data_b;

  // Single-cycle result mux and signed overflow flag
  always_comb begin
    alu_out = '0;
    alu_ovf = 1'b0;
    case (i_ALUctl)
      OP_AND:  alu_out = i_data_a & i_data_b;
      OP_OR:   alu_out = i_data_a | i_data_b;
      OP_ADD: begin
        alu_out = add_res;
        alu_ovf = (i_data_a[MSB] == i_data_b[MSB]) && (add_res[MSB] != i_data_a[MSB]);
      end
      OP_SUB: begin
        alu_out = sub_res;
        alu_ovf = (i_data_a[MSB] != i_data_b[MSB]) && (sub_res[MSB] != i_data_a[MSB]);
      end
      OP_NOR:  alu_out = ~(i_data_a | i_data_b);
      OP_XOR:  alu_out = i_data_a ^ i_data_b;
      OP_SLT:  alu_out = {{(NB_DATA-1){1'b0}}, ($signed(i_data_a) < $signed(i_data_b))};
      OP_SLTU: alu_out = {{(NB_DATA-1){1'b0}}, (i_data_a < i_data_b)};
      OP_SLL:  alu_out = i_data_b << i_shamt;
      OP_SRL:  alu_out = i_data_b >> i_shamt;
      OP_SRA:  alu_out = $unsigned($signed(i_data_b) >>> i_shamt);
      OP_LUI:  alu_out = i_data_b << (NB_DATA / 2);
      OP_MFHI: alu_out = hi_reg;
      OP_MFLO: alu_out = lo_reg;
      default: begin
        alu_out = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  assign o_ALUOut   = alu_out;
  assign o_zero     = (alu_out == '0);
  assign o_overflow = alu_ovf;
  assign o_busy     = (state_reg != ST_IDLE);
  assign o_done     = done_reg;

endmodule

// File: tb/tb_seg_execute_alu_mc.sv
// tb_seg_execute_alu_mc: randomized scoreboard bench for seg_execute_alu_mc.
// Stimulus pushes expected results into queues; a negedge monitor pops and
// compares whenever a combinational check is strobed or o_done pulses.
module tb_seg_execute_alu_mc;

  localparam logic [4:0] OP_ADD   = 5'b00010;
  localparam logic [4:0] OP_AND   = 5'b00000;
  localparam logic [4:0] OP_OR    = 5'b00001;
  localparam logic [4:0] OP_SUB   = 5'b00110;
  localparam logic [4:0] OP_SLT   = 5'b00111;
  localparam logic [4:0] OP_SLTU  = 5'b01000;
  localparam logic [4:0] OP_NOR   = 5'b01100;
  localparam logic [4:0] OP_XOR   = 5'b01101;
  localparam logic [4:0] OP_SLL   = 5'b10000;
  localparam logic [4:0] OP_SRL   = 5'b10001;
  localparam logic [4:0] OP_SRA   = 5'b10010;
  localparam logic [4:0] OP_LUI   = 5'b10011;
  localparam logic [4:0] OP_MULT  = 5'b11000;
  localparam logic [4:0] OP_MULTU = 5'b11001;
  localparam logic [4:0] OP_DIV   = 5'b11010;
  localparam logic [4:0] OP_DIVU  = 5'b11011;
  localparam logic [4:0] OP_MFHI  = 5'b11100;
  localparam logic [4:0] OP_MFLO  = 5'b11101;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_flush = 1'b0;
  logic [4:0]  i_ALUctl = 5'b0;
  logic [31:0] i_data_a = '0;
  logic [31:0] i_data_b = '0;
  logic [4:0]  i_shamt = '0;
  logic [31:0] o_ALUOut;
  logic        o_zero;
  logic        o_overflow;
  logic        o_busy;
  logic        o_done;

  typedef struct {
    logic [4:0]  ctl;
    logic [31:0] out;
    logic        zero;
    logic        ovf;
  } exp_t;

  exp_t        comb_q[$];
  logic [31:0] done_q[$];
  exp_t        mon_e;
  logic [31:0] mon_hi;
  logic        chk_strobe = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          done_expected = 0;
  int          done_seen = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;
  logic [31:0] special_vals [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

  seg_execute_alu_mc #(.NB_DATA(32), .NB_ALUCTL(5), .NB_SHAMT(5)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (i_valid),
    .i_flush    (i_flush),
    .i_ALUctl   (i_ALUctl),
    .i_data_a   (i_data_a),
    .i_data_b   (i_data_b),
    .i_shamt    (i_shamt),
    .o_ALUOut   (o_ALUOut),
    .o_zero     (o_zero),
    .o_overflow (o_overflow),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 clk = ~clk;

  // Reference model of the single-cycle ops, from the arithmetic definitions
  function automatic void model_comb(input logic [4:0] ctl, input logic [31:0] a, b,
                                     input logic [4:0] sh, output logic [31:0] out,
                                     output logic ovf);
    longint s;
    out = '0;
    ovf = 1'b0;
    case (ctl)
      OP_AND:  out = a & b;
      OP_OR:   out = a | b;
      OP_NOR:  out = ~(a | b);
      OP_XOR:  out = a ^ b;
      OP_ADD: begin
        s = longint'($signed(a)) + longint'($signed(b));
        out = s[31:0];
        ovf = (s > SMAX) || (s < SMIN);
      end
      OP_SUB: begin
        s = longint'($signed(a)) - longint'($signed(b));
        out = s[31:0];
        ovf = (s > SMAX) || (s < SMIN);
      end
      OP_SLT:  out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: out = (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  out = b << sh;
      OP_SRL:  out = b >> sh;
      OP_SRA:  out = $unsigned($signed(b) >>> sh);
      OP_LUI:  out = {b[15:0], 16'h0};
      OP_MFHI: out = model_hi;
      OP_MFLO: out = model_lo;
      default: out = '0;
    endcase
  endfunction

  // Reference model of mul/div results as {HI, LO}
  function automatic logic [63:0] model_md(input logic [4:0] ctl, input logic [31:0] a, b);
    longint sa, sb, q, r, p;
    longint unsigned pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (ctl)
      OP_MULT: begin
        p = sa * sb;
        return p;
      end
      OP_MULTU: begin
        pu = {32'h0, a} * {32'h0, b};
        return pu;
      end
      OP_DIV: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 3) == 0) return special_vals[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a result
  always @(negedge clk) begin
    if (chk_strobe) begin
      checks++;
      if (comb_q.size() == 0) begin
        errors++;
        $display("FAIL comb_underflow no expectation queued");
      end else begin
        mon_e = comb_q.pop_front();
        if (o_ALUOut !== mon_e.out || o_zero !== mon_e.zero || o_overflow !== mon_e.ovf) begin
          errors++;
          $display("FAIL comb ctl=%b got out=%h zero=%b ovf=%b expected out=%h zero=%b ovf=%b",
                   mon_e.ctl, o_ALUOut, o_zero, o_overflow, mon_e.out, mon_e.zero, mon_e.ovf);
        end else begin
          $display("comb ctl=%b out=%h zero=%b ovf=%b ok", mon_e.ctl, o_ALUOut, o_zero, o_overflow);
        end
      end
    end
    if (o_done === 1'b1) begin
      done_seen++;
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected got o_done=1 expected 0");
      end else begin
        mon_hi = done_q.pop_front();
        if (o_ALUOut !== mon_hi) begin
          errors++;
          $display("FAIL done_hi got %h expected %h", o_ALUOut, mon_hi);
        end else begin
          $display("done hi=%h ok", o_ALUOut);
        end
      end
    end
  end

  task automatic comb_check(input logic [4:0] ctl, input logic [31:0] a, b, input logic [4:0] sh);
    exp_t        e;
    logic [31:0] o;
    logic        v;
    i_valid  = 1'b0;
    i_ALUctl = ctl;
    i_data_a = a;
    i_data_b = b;
    i_shamt  = sh;
    model_comb(ctl, a, b, sh, o, v);
    e.ctl  = ctl;
    e.out  = o;
    e.zero = (o == 32'h0);
    e.ovf  = v;
    comb_q.push_back(e);
    chk_strobe = 1'b1;
    @(posedge clk);
    #1 chk_strobe = 1'b0;
  endtask

  task automatic issue(input logic [4:0] ctl, input logic [31:0] a, b, input logic flush);
    i_valid  = 1'b1;
    i_flush  = flush;
    i_ALUctl = ctl;
    i_data_a = a;
    i_data_b = b;
    @(posedge clk);
    #1;
    i_valid  = 1'b0;
    i_flush  = 1'b0;
    i_ALUctl = OP_MFHI;
  endtask

  // Full mul/div transaction: latency, done pulse, HI/LO readback
  task automatic muldiv(input logic [4:0] ctl, input logic [31:0] a, b, input bit poke);
    logic [63:0] exp;
    int          busy_cnt;
    exp = model_md(ctl, a, b);
    $display("md ctl=%b a=%h b=%h expect hi=%h lo=%h", ctl, a, b, exp[63:32], exp[31:0]);
    done_q.push_back(exp[63:32]);
    done_expected++;
    issue(ctl, a, b, 1'b0);
    busy_cnt = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!o_busy) break;
      busy_cnt++;
      if (poke && busy_cnt == 3) begin
        i_valid  = 1'b1;
        i_ALUctl = OP_DIVU;
        i_data_a = $urandom;
        i_data_b = $urandom;
      end
      if (poke && busy_cnt == 4) begin
        i_valid  = 1'b0;
        i_ALUctl = OP_MFHI;
      end
    end
    check_val("busy_len", 32'(busy_cnt), 32'd33);
    @(posedge clk);
    #1;
    check_val("done_missing", 32'(done_q.size()), 32'd0);
    done_q.delete();
    model_hi = exp[63:32];
    model_lo = exp[31:0];
    comb_check(OP_MFHI, '0, '0, '0);
    comb_check(OP_MFLO, '0, '0, '0);
  endtask

  initial begin
    logic [4:0]  ctl;
    logic [31:0] a, b;
    logic [4:0]  md_ops [4] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", {31'b0, o_busy}, 32'd0);
    check_val("rst_done", {31'b0, o_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    comb_check(OP_MFHI, '0, '0, '0);
    comb_check(OP_MFLO, '0, '0, '0);

    // Directed single-cycle cases
    comb_check(OP_ADD, 32'h7FFF_FFFF, 32'h1, '0);
    comb_check(OP_SUB, 32'd5, 32'd5, '0);
    comb_check(OP_SUB, 32'h8000_0000, 32'h1, '0);
    comb_check(OP_SLT, 32'hFFFF_FFFF, 32'h1, '0);
    comb_check(OP_SLTU, 32'hFFFF_FFFF, 32'h1, '0);
    comb_check(OP_SRA, '0, 32'h8000_0000, 5'd4);
    comb_check(OP_SRL, '0, 32'h8000_0000, 5'd4);
    comb_check(OP_LUI, '0, 32'h0000_1234, '0);
    comb_check(OP_MULT, 32'h5, 32'h6, '0);
    comb_check(5'b11111, 32'h5, 32'h6, '0);

    // Directed mul/div cases
    muldiv(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    muldiv(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
    muldiv(OP_DIVU, 32'd7, 32'd0, 1'b0);
    muldiv(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    muldiv(OP_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0);

    // Random single-cycle ops over every code
    for (int i = 0; i < 80; i++) begin
      ctl = 5'($urandom_range(0, 31));
      comb_check(ctl, pick(), pick(), 5'($urandom));
    end

    // Random mul/div
    for (int i = 0; i < 8; i++) begin
      a = pick();
      b = pick();
      muldiv(md_ops[$urandom_range(0, 3)], a, b, bit'(i % 2));
    end

    // Flush in the 10th busy cycle of a MULTU
    issue(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    for (int n = 0; n < 10; n++) @(negedge clk);
    check_val("flush_pre_busy", {31'b0, o_busy}, 32'd1);
    i_flush = 1'b1;
    @(posedge clk);
    #1 i_flush = 1'b0;
    check_val("flush_busy", {31'b0, o_busy}, 32'd0);
    comb_check(OP_MFHI, '0, '0, '0);
    comb_check(OP_MFLO, '0, '0, '0);
    muldiv(OP_DIVU, 32'd1000, 32'd7, 1'b0);

    // Flush on the accept edge suppresses the start
    issue(OP_MULT, 32'd3, 32'd4, 1'b1);
    check_val("flush_accept_busy", {31'b0, o_busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a DIV
    issue(OP_DIV, 32'h7654_3210, 32'd13, 1'b0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_busy", {31'b0, o_busy}, 32'd0);
    check_val("arst_done", {31'b0, o_done}, 32'd0);
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    comb_check(OP_MFHI, '0, '0, '0);
    comb_check(OP_MFLO, '0, '0, '0);

    repeat (40) @(posedge clk);
    #1;
    check_val("done_count", 32'(done_seen), 32'(done_expected));
    check_val("comb_drain", 32'(comb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_execute_alu_mc.md
Name: seg_execute_alu_mc

Overview:
- Next-generation execute-stage ALU, parametrised in data width.
- Keeps the single-cycle logic/arith ops and adds:
  - signed/unsigned compare, shifts, LUI
  - signed add/sub overflow flag
  - iterative multiply/divide unit writing internal HI/LO registers
- Sits in the EX stage. o_busy drives the hazard unit's stall while a mul/div runs. MFHI/MFLO read HI/LO through o_ALUOut.

Parameters:
- NB_DATA, 32, operand/result width (even, >=8)
- NB_ALUCTL, 5, ALU control code width
- NB_SHAMT, 5, shift amount width (= clog2(NB_DATA))

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_valid  in  1  instruction valid in EX (not stalled, not bubble)
- i_flush  in  1  abort any in-flight mul/div (synchronous)
- i_ALUctl  in  NB_ALUCTL  operation code
- i_data_a  in  NB_DATA  operand A (rs)
- i_data_b  in  NB_DATA  operand B (rt/immediate)
- i_shamt  in  NB_SHAMT  shift amount
- o_ALUOut  out  NB_DATA  combinational result
- o_zero  out  1  o_ALUOut == 0
- o_overflow  out  1  signed overflow for ADD/SUB, else 0
- o_busy  out  1  mul/div in progress (state != IDLE)
- o_done  out  1  one-cycle pulse: HI/LO just updated

Behaviour:
Combinational ops (result same cycle, independent of i_valid):
- 00000 AND; 00001 OR; 00010 ADD; 00110 SUB; 01100 NOR; 01101 XOR
- 00111 SLT (signed) and 01000 SLTU: result 1 or 0, zero-extended
- 10000 SLL b<<shamt; 10001 SRL b>>shamt; 10010 SRA arithmetic b>>shamt
- 10011 LUI: b<<(NB_DATA/2)
- 11100 MFHI: HI; 11101 MFLO: LO
- 11000 MULT, 11001 MULTU, 11010 DIV, 11011 DIVU: o_ALUOut = 0
- Any other code: o_ALUOut = 0, o_overflow = 0
- o_overflow:
  - ADD: operands same sign and result sign differs
  - SUB: operands differ in sign and result sign differs from a
  - Flag only; o_ALUOut still holds the wrapped result.

Iterative unit, FSM states IDLE, RUN, FIX:
- Accept: at an edge with state IDLE, i_valid=1, i_flush=0 and op in {MULT, MULTU, DIV, DIVU}.
  - Latch operands as magnitudes (signed ops) plus result-sign bits.
  - Counter <= NB_DATA; state -> RUN.
- RUN: one iteration per edge.
  - Multiply: shift-add, 2*NB_DATA product.
  - Divide: restoring, one quotient bit per edge.
  - Counter decrements; after NB_DATA iterations state -> FIX.
- FIX edge:
  - Apply sign correction.
  - Multiply: HI = upper half, LO = lower half.
  - Divide: LO = quotient, HI = remainder; remainder takes the sign of the dividend; quotient truncates toward zero.
  - Write HI/LO; o_done <= 1 for exactly one cycle; state -> IDLE.
- Latency:
  - o_busy is high for NB_DATA+1 cycles after the accept edge.
  - HI/LO and o_done are visible in the cycle after the FIX edge.
- Divide by zero (DIV/DIVU): LO = all ones, HI = dividend. No exception.
- DIV of most-negative by -1: LO = most-negative, HI = 0.
- Any valid op arriving while busy is ignored by the unit. The hazard unit must keep it stalled.
- MFHI/MFLO while busy return the old HI/LO. The stall makes this unobservable architecturally.
- i_flush=1 at any edge:
  - state -> IDLE, o_done stays 0, HI/LO unchanged.
  - The same-edge accept is suppressed.
  - Flush has priority over FIX.
- Reset (async, any time, including mid-operation): state IDLE, counter 0, HI = LO = 0, o_done = 0, o_busy = 0.
  - Combinational outputs follow the inputs, with HI/LO = 0.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 -> o_ALUOut = 0x80000000, o_overflow = 1, o_zero = 0. SUB 5-5 -> 0, o_zero = 1.
- SLT a = 0xFFFFFFFF, b = 1 -> 1; SLTU same operands -> 0. SRA 0x80000000 by 4 -> 0xF8000000; SRL -> 0x08000000.
- MULT -3 × 7 -> o_busy high 33 cycles, o_done pulse once, then MFHI = 0xFFFFFFFF, MFLO = 0xFFFFFFEB.
- DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 7 / 0 -> LO = 0xFFFFFFFF, HI = 0x00000007.
- MULTU started, i_flush at 10th busy cycle -> o_busy low next cycle, no o_done, HI/LO keep their prior values. A new DIVU then completes normally.
- i_rst_n pulsed low mid-DIV -> o_busy = 0 and o_done = 0 immediately (asynchronously). MFHI/MFLO = 0 after reset.
